fetch_cycle: RTL and testbench
==============================

# fetch_cycle

Instruction-fetch stage of the 5-stage pipelined RISC-V core. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register for the decode stage. It obeys stall, flush and branch-redirect controls from the hazard unit and execute stage, and keeps a fetched-instruction counter for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on reset or flush (`addi x0,x0,0`)
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, synchronous and active-high
- PCSrcE  input  1  redirect request from execute (taken branch / jump)
- PCTargetE  input  32  redirect target; bits [1:0] are ignored and treated as 00
- StallF  input  1  hold PCF
- StallD  input  1  hold the IF/ID register
- FlushD  input  1  replace the IF/ID contents with a bubble
- InstrF  input  32  instruction read combinationally from instruction memory at PCF
- PCF  output  32  current fetch address, registered, always word-aligned
- InstrD  output  32  IF/ID instruction
- PCD  output  32  IF/ID PC of InstrD
- PCPlus4D  output  32  IF/ID PC+4 of InstrD
- ValidD  output  1  IF/ID holds a real fetched instruction (0 = bubble)
- FetchCount  output  32  number of instructions captured with ValidD=1

## Operation
- PCPlus4F = PCF + 4, 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- PC register next-value priority, evaluated at each rising edge:
  - rst: PCF <= RESET_PC.
  - PCSrcE: PCF <= {PCTargetE[31:2], 2'b00}. This overrides StallF.
  - StallF: PCF holds.
  - otherwise: PCF <= PCPlus4F.
- IF/ID register priority:
  - rst: InstrD <= NOP_INSTR, PCD <= 0, PCPlus4D <= 0, ValidD <= 0.
  - FlushD: same values as reset. Flush overrides StallD.
  - StallD: all IF/ID fields hold.
  - otherwise: InstrD <= InstrF, PCD <= PCF, PCPlus4D <= PCPlus4F, ValidD <= 1.
- FetchCount: reset to 0. Increments by 1 on every edge where the IF/ID register performs the capture branch (no rst, no FlushD, no StallD). Wraps modulo 2^32.
- The block does not flush itself on PCSrcE. The hazard unit asserts FlushD (and FlushE) in the same cycle as PCSrcE.
- PCF[1:0] is always 00. The memory is indexed by PCF[31:2].

## Timing
- Reset values: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FetchCount=0. They appear at the first edge with rst=1 and hold while rst stays high.
- Reset applied mid-operation takes effect at the next edge and overrides all other controls.
- In the first cycle after rst falls, PCF=RESET_PC. At the end of that cycle the instruction at RESET_PC is captured, so ValidD=1 from the second cycle onward.
- Latency: an instruction is fetched in cycle N (PCF valid, InstrF combinational in the same cycle) and is visible on InstrD in cycle N+1.
- Redirect: with PCSrcE=1 in cycle N, PCF equals the target in cycle N+1 and the target instruction reaches InstrD in cycle N+2.
- StallF=1 with StallD=1 (load-use): PCF and IF/ID are both frozen for exactly the stalled cycles, and FetchCount does not advance.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then free-run with InstrF = memory image {mem[0]=32'h0062E233, mem[1]=32'h00B62423, ...}. Required:
  - PCF = 0, 4, 8 on consecutive cycles.
  - InstrD = 32'h0062E233 with PCD=0 and PCPlus4D=4 one cycle after PCF=0.
  - ValidD rises on the second post-reset cycle.
  - FetchCount = 3 after three captures.
- Stall: assert StallF=StallD=1 for 2 cycles while PCF=8. Required: PCF stays 8, InstrD stays the PC=4 instruction, FetchCount is unchanged. Resume: PCF becomes 12.
- Redirect with flush: PCSrcE=1, PCTargetE=32'h0000_0043, FlushD=1 at PCF=16. Required:
  - Next cycle: PCF=32'h40, InstrD=32'h0000_0013, ValidD=0, FetchCount unchanged.
  - Following cycle: PCD=32'h40.
- Redirect during stall: PCSrcE=1 together with StallF=1, target 32'h100. Required: PCF=32'h100 on the next cycle. FlushD=1 together with StallD=1: IF/ID becomes a bubble.
- Wrap: force the PC to 32'hFFFF_FFFC via a redirect. Required: next PCF=0 and PCPlus4D=0 for the captured instruction.
- Reset mid-run (rst=1 for 1 cycle at PCF=24). Required: PCF=RESET_PC, InstrD=NOP_INSTR, ValidD=0, FetchCount=0 on the next cycle, after which fetch restarts from 0.

Source files
------------

// File: rtl/fetch_cycle.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID pipeline register under stall, flush and redirect control.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchCount
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4d_q, pcp4d_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic        capture;

    assign pc_plus4 = pc_q + 32'd4;
    assign capture  = !FlushD && !StallD;

    // A redirect wins over StallF so a taken branch is never lost behind a stall.
    always_comb begin
        pc_d = pc_plus4;
        if (PCSrcE) begin
            pc_d = {PCTargetE[31:2], 2'b00};
        end else if (StallF) begin
            pc_d = pc_q;
        end
    end

    // ValidD qualifies the IF/ID contents; StallD is the only backpressure and
    // holds them, while FlushD (even under stall) turns them into a bubble.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        count_d = count_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4d_d = 32'd0;
            valid_d = 1'b0;
        end else if (capture) begin
            instr_d = InstrF;
            pcd_d   = pc_q;
            pcp4d_d = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4d_q <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4d_q <= pcp4d_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign PCF        = pc_q;
    assign InstrD     = instr_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pcp4d_q;
    assign ValidD     = valid_q;
    assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: directed walk through fetch, stall, redirect, wrap and
// reset scenarios, then random control traffic against a cycle-level model.
module tb_fetch_cycle;

    localparam int W = 161;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] FetchCount;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // reference model state: what the outputs must be after the next edge
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
    logic        m_valid;

    fetch_cycle dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .FetchCount(FetchCount)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [29:0] idx;
        idx = addr[31:2];
        if (idx == 30'd0) return 32'h0062E233;
        if (idx == 30'd1) return 32'h00B62423;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // instruction memory: combinational read at the DUT's fetch address
    assign InstrF = mem_word(PCF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of controls and push the model's post-edge state
    task automatic drive(input logic r, input logic ps, input logic [31:0] tgt,
                         input logic sf, input logic sd, input logic fd);
        logic [31:0] next_pc;
        @(negedge clk);
        rst = r; PCSrcE = ps; PCTargetE = tgt; StallF = sf; StallD = sd; FlushD = fd;
        if (r) begin
            m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0;
            m_valid = 1'b0; m_cnt = 32'd0;
        end else begin
            if (ps)      next_pc = {tgt[31:2], 2'b00};
            else if (sf) next_pc = m_pc;
            else         next_pc = m_pc + 32'd4;
            if (fd) begin
                m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0;
            end else if (!sd) begin
                m_instr = mem_word(m_pc); m_pcd = m_pc; m_pcp4 = m_pc + 32'd4;
                m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end
            m_pc = next_pc;
        end
        exp_q.push_back({m_pc, m_instr, m_pcd, m_pcp4, m_valid, m_cnt});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // wait until just after the edge that follows the last drive
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // monitor / scoreboard: every edge after a drive has a pending expectation
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("PCF",        PCF,                 e[160:129]);
                chk("InstrD",     InstrD,              e[128:97]);
                chk("PCD",        PCD,                 e[96:65]);
                chk("PCPlus4D",   PCPlus4D,            e[64:33]);
                chk("ValidD",     {31'd0, ValidD},     {31'd0, e[32]});
                chk("FetchCount", FetchCount,          e[31:0]);
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'd0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0;
        m_valid = 1'b0; m_cnt = 32'd0;

        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rst_pcf",   PCF, 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_cnt",   FetchCount, 32'd0);

        // free run from reset
        run(1); settle();
        chk("fr_pcf4",   PCF, 32'd4);
        chk("fr_instr0", InstrD, 32'h0062E233);
        chk("fr_pcd0",   PCD, 32'd0);
        chk("fr_pcp4_0", PCPlus4D, 32'd4);
        chk("fr_valid",  {31'd0, ValidD}, 32'd1);
        run(1); settle();
        chk("fr_pcf8",   PCF, 32'd8);

        // load-use stall at PCF=8
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        settle();
        chk("st_pcf",    PCF, 32'd8);
        chk("st_instr",  InstrD, 32'h00B62423);
        chk("st_cnt",    FetchCount, 32'd2);
        run(1); settle();
        chk("st_resume", PCF, 32'd12);
        chk("cnt3",      FetchCount, 32'd3);

        // redirect with flush at PCF=16
        run(1);
        drive(1'b0, 1'b1, 32'h0000_0043, 1'b0, 1'b0, 1'b1);
        settle();
        chk("rd_pcf",    PCF, 32'h40);
        chk("rd_instr",  InstrD, NOP);
        chk("rd_valid",  {31'd0, ValidD}, 32'd0);
        chk("rd_cnt",    FetchCount, 32'd4);
        run(1); settle();
        chk("rd_pcd",    PCD, 32'h40);

        // redirect under StallF, then flush under StallD
        drive(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        settle();
        chk("rs_pcf",    PCF, 32'h100);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        settle();
        chk("fs_valid",  {31'd0, ValidD}, 32'd0);
        chk("fs_instr",  InstrD, NOP);

        // PC wrap
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        run(1); settle();
        chk("wr_pcf",    PCF, 32'd0);
        chk("wr_pcp4d",  PCPlus4D, 32'd0);
        chk("wr_pcd",    PCD, 32'hFFFF_FFFC);

        // reset mid-run at PCF=24
        run(6);
        drive(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
        settle();
        chk("mr_pcf",    PCF, 32'd0);
        chk("mr_instr",  InstrD, NOP);
        chk("mr_valid",  {31'd0, ValidD}, 32'd0);
        chk("mr_cnt",    FetchCount, 32'd0);
        run(1); settle();
        chk("mr_restart", PCF, 32'd4);

        // random control traffic
        for (int i = 0; i < 400; i++) begin
            logic r, ps, sf, sd, fd;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) < 2);
            ps = ($urandom_range(0, 99) < 12);
            sf = ($urandom_range(0, 99) < 20);
            sd = sf ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 10);
            fd = ps ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 5);
            t  = $urandom;
            drive(r, ps, t, sf, sd, fd);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #3;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
